udma_qspi_cmd_seq: RTL and testbench
====================================

UDMA_QSPI_CMD_SEQ -- requirements
Module: udma_qspi_cmd_seq

Interface
REQ-001 SHALL: sys_clk_i  in  1  single clock; all state on rising edge.
REQ-002 SHALL: rst_i  in  1  reset, asynchronous, active-high.
REQ-003 SHALL: req_valid_i / req_ready_o  in/out  1/1  transaction request handshake.
REQ-004 SHALL: req_op_i  in  2  operation: 0=read, 1=write, 2=command-only, 3=reserved (treated as 2).
REQ-005 SHALL: req_instr_i  in  8  flash instruction byte.
REQ-006 SHALL: req_addr_i  in  32  flash address.
REQ-007 SHALL: req_addr_bytes_i  in  3  address bytes 0..4; values above 4 treated as 4.
REQ-008 SHALL: req_dummy_i  in  5  dummy cycles; 0 means no dummy phase.
REQ-009 SHALL: req_len_i  in  16  data bytes; 0 means no data phase.
REQ-010 SHALL: req_qpi_i / req_csn_i  in  1/2  quad mode / chip select index.
REQ-011 SHALL: abort_i  in  1  request early termination.
REQ-012 SHALL: cmd_o / cmd_valid_o / cmd_ready_i  out/out/in  32/1/1  SPI-master command word stream.
REQ-013 SHALL: eot_i  in  1  end-of-transfer pulse from the SPI master.
REQ-014 SHALL: busy_o / done_o  out/out  1/1  transaction in flight / one-cycle completion pulse.

Function
REQ-015 SHALL: word format: [31:28] opcode (SOT=1, SEND_CMD=2, DUMMY=4, TX_DATA=6, RX_DATA=7, EOT=9); [27] qpi; remaining bits zero unless specified.
REQ-016 SHALL: SOT carries req_csn_i in [1:0]; SEND_CMD carries bit count minus 1 in [19:16] and data in [15:0], right-aligned; DUMMY carries cycles minus 1 in [20:16]; TX/RX_DATA carry bytes minus 1 in [15:0]; EOT sets [0]=1.
REQ-017 SHALL: FSM states IDLE, SOT, INSTR, ADDR_HI, ADDR_LO, DUMMY, DATA, EOT, WAIT_EOT.
REQ-018 SHALL: in IDLE, req_ready_o=1; on req_valid_i, all req_* fields latch and the FSM enters SOT next cycle.
REQ-019 SHALL: each state other than IDLE and WAIT_EOT drives exactly one word, with cmd_valid_o=1, and advances only on the cycle cmd_valid_o && cmd_ready_i.
REQ-020 SHALL: cmd_o stays stable while cmd_valid_o=1 and cmd_ready_i=0.
REQ-021 SHALL: INSTR always emits SEND_CMD with 8 bits (field 7) and req_instr_i.
REQ-022 SHALL: address words by byte count:
  - 0: no address words.
  - 1: one word, 8 bits, addr[7:0].
  - 2: one word, 16 bits, addr[15:0].
  - 3: ADDR_HI 16 bits addr[23:8], then ADDR_LO 8 bits addr[7:0].
  - 4: ADDR_HI addr[31:16], then ADDR_LO addr[15:0].
REQ-023 SHALL: single-word address cases use state ADDR_LO only.
REQ-024 SHALL: DUMMY is skipped when latched dummy=0.
REQ-025 SHALL: DATA is skipped when len=0 or op=command-only; it emits RX_DATA for read and TX_DATA for write.
REQ-026 SHALL: skipped states consume zero cycles; the next applicable state is selected in the same transition.
REQ-027 SHALL: after the EOT word handshakes, the FSM enters WAIT_EOT.
REQ-028 SHALL: in WAIT_EOT, on eot_i the FSM pulses done_o for one cycle and returns to IDLE; eot_i in any other state is ignored.
REQ-029 SHALL: busy_o=1 in every state except IDLE; req_ready_o=0 outside IDLE.
REQ-030 SHALL: abort_i sampled high in SOT..DATA sets a sticky abort flag; after the current word's handshake, the FSM goes to EOT.
REQ-031 SHALL: abort_i in IDLE, EOT or WAIT_EOT has no effect; the flag clears on return to IDLE.
REQ-032 SHALL: abort and handshake in the same cycle complete the current word first; there is no word truncation.
REQ-033 SHALL: latency from request accept to first cmd_valid_o is 1 cycle; minimum word spacing with cmd_ready_i=1 is 1 cycle.

Reset
REQ-034 SHALL: on rst_i the FSM goes to IDLE, and cmd_valid_o=0, cmd_o=0, busy_o=0, done_o=0, req_ready_o=1, and the abort flag and latched fields clear.
REQ-035 SHALL: reset mid-transaction drops any pending word without completing its handshake.

Verification
REQ-036 SHALL: read test: instr 0xEB, addr 0x00123456, 3 bytes, dummy 6, len 256, qpi 1, csn 1, ready always 1 -> words 0x10000001, 0x2807_00EB, 0x280F_1234, 0x2807_0056, 0x4005_0000, 0x780000FF, 0x90000001 on consecutive cycles; done_o one cycle after eot_i.
REQ-037 SHALL: command-only test: instr 0x06, 0 address bytes, dummy 0, op 2 -> exactly SOT, SEND_CMD 0x06, EOT.
REQ-038 SHALL: backpressure test: cmd_ready_i toggles randomly -> cmd_o stable while stalled and word sequence identical to the no-stall run.
REQ-039 SHALL: abort test: abort_i during ADDR_HI with ready=0 -> ADDR_HI completes, then EOT, no DUMMY or DATA words.
REQ-040 SHALL: reset test: rst_i asserted in DATA with cmd_valid_o=1 -> next cycle cmd_valid_o=0, busy_o=0, req_ready_o=1; a following request runs normally.
REQ-041 SHALL: eot_i pulsed in IDLE and in DATA -> no done_o; 4-byte address 0xDEADBEEF -> words carrying 0xDEAD then 0xBEEF, both with bits field 15.

Source files
------------

// File: rtl/udma_qspi_cmd_seq.sv
// -----------------------------------------------------------------------------
// udma_qspi_cmd_seq
//
// Turns one flash transaction request into the stream of 32-bit command words
// consumed by the uDMA SPI master. The order is: SOT, instruction, optional
// address word(s), optional dummy, optional data, and EOT. After EOT the
// sequencer waits for the master's end-of-transfer pulse, then reports
// completion.
//
// Ports
//   sys_clk_i, rst_i          clock, asynchronous active-high reset
//   req_valid_i / req_ready_o request handshake (ready only while idle)
//   req_op_i                  0=read, 1=write, 2/3=command only
//   req_instr_i               instruction byte
//   req_addr_i                flash address
//   req_addr_bytes_i          address bytes 0..4 (larger values mean 4)
//   req_dummy_i               dummy cycles (0 = none)
//   req_len_i                 data bytes (0 = none)
//   req_qpi_i, req_csn_i      quad mode flag, chip-select index
//   abort_i                   finish the current word, then jump to EOT
//   cmd_o / cmd_valid_o / cmd_ready_i  command word stream
//   eot_i                     end-of-transfer pulse from the SPI master
//   busy_o / done_o           transaction in flight / completion pulse
// -----------------------------------------------------------------------------
module udma_qspi_cmd_seq (
  input  logic        sys_clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [7:0]  req_instr_i,
  input  logic [31:0] req_addr_i,
  input  logic [2:0]  req_addr_bytes_i,
  input  logic [4:0]  req_dummy_i,
  input  logic [15:0] req_len_i,
  input  logic        req_qpi_i,
  input  logic [1:0]  req_csn_i,
  input  logic        abort_i,
  output logic [31:0] cmd_o,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  input  logic        eot_i,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [3:0] {
    IDLE, SOT, INSTR, ADDR_HI, ADDR_LO, DUMMY, DATA, EOT, WAIT_EOT
  } state_t;

  state_t      state_reg, state_next, adv_state;
  logic [1:0]  op_reg;
  logic [7:0]  instr_reg;
  logic [31:0] addr_reg;
  logic [2:0]  addr_bytes_reg;
  logic [4:0]  dummy_reg;
  logic [15:0] len_reg;
  logic        qpi_reg;
  logic [1:0]  csn_reg;
  logic        abort_reg;
  logic        done_reg;

  logic [31:0] cmd_word;
  logic        cmd_valid;
  logic        has_data;
  logic        abortable;
  logic        abort_now;
  state_t      after_addr;
  state_t      after_dummy;

  // SEND_CMD word: bit count minus one in [19:16], payload right-aligned.
  // Only words that shift bits on the data lanes carry the qpi flag.
  function automatic logic [31:0] send_cmd(input logic [3:0] bits_m1,
                                           input logic [15:0] data,
                                           input logic qpi);
    return {4'h2, qpi, 7'd0, bits_m1, data};
  endfunction

  assign has_data    = (len_reg != 16'd0) && !op_reg[1];
  assign after_dummy = has_data ? DATA : EOT;
  assign after_addr  = (dummy_reg != 5'd0) ? DUMMY : after_dummy;
  assign abortable   = (state_reg == SOT) || (state_reg == INSTR) ||
                       (state_reg == ADDR_HI) || (state_reg == ADDR_LO) ||
                       (state_reg == DUMMY) || (state_reg == DATA);
  // An abort sampled on the handshake cycle still lets the current word go.
  assign abort_now   = abort_reg || (abort_i && abortable);

  always_comb begin
    state_next = state_reg;
    adv_state  = state_reg;
    cmd_word   = 32'd0;
    cmd_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid_i) state_next = SOT;
      end
      SOT: begin
        cmd_valid = 1'b1;
        cmd_word  = {4'h1, 26'd0, csn_reg};
        adv_state = INSTR;
      end
      INSTR: begin
        cmd_valid = 1'b1;
        cmd_word  = send_cmd(4'd7, {8'd0, instr_reg}, qpi_reg);
        if (addr_bytes_reg == 3'd0)      adv_state = after_addr;
        else if (addr_bytes_reg <= 3'd2) adv_state = ADDR_LO;
        else                             adv_state = ADDR_HI;
      end
      ADDR_HI: begin
        cmd_valid = 1'b1;
        cmd_word  = (addr_bytes_reg == 3'd3) ?
                    send_cmd(4'd15, addr_reg[23:8], qpi_reg) :
                    send_cmd(4'd15, addr_reg[31:16], qpi_reg);
        adv_state = ADDR_LO;
      end
      ADDR_LO: begin
        // 1- and 3-byte addresses end on a single byte, 2 and 4 on a half-word
        cmd_valid = 1'b1;
        cmd_word  = addr_bytes_reg[0] ?
                    send_cmd(4'd7, {8'd0, addr_reg[7:0]}, qpi_reg) :
                    send_cmd(4'd15, addr_reg[15:0], qpi_reg);
        adv_state = after_addr;
      end
      DUMMY: begin
        cmd_valid = 1'b1;
        cmd_word  = {4'h4, 1'b0, 6'd0, dummy_reg - 5'd1, 16'd0};
        adv_state = after_dummy;
      end
      DATA: begin
        cmd_valid = 1'b1;
        cmd_word  = {(op_reg[0] ? 4'h6 : 4'h7), qpi_reg, 11'd0, len_reg - 16'd1};
        adv_state = EOT;
      end
      EOT: begin
        cmd_valid = 1'b1;
        cmd_word  = {4'h9, 27'd0, 1'b1};
        adv_state = WAIT_EOT;
      end
      WAIT_EOT: begin
        if (eot_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (cmd_valid && cmd_ready_i)
      state_next = (abort_now && state_reg != EOT) ? EOT : adv_state;
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      op_reg         <= 2'd0;
      instr_reg      <= 8'd0;
      addr_reg       <= 32'd0;
      addr_bytes_reg <= 3'd0;
      dummy_reg      <= 5'd0;
      len_reg        <= 16'd0;
      qpi_reg        <= 1'b0;
      csn_reg        <= 2'd0;
      abort_reg      <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_reg == WAIT_EOT) && eot_i;
      if (state_reg == IDLE) begin
        abort_reg <= 1'b0;
        if (req_valid_i) begin
          op_reg         <= req_op_i;
          instr_reg      <= req_instr_i;
          addr_reg       <= req_addr_i;
          addr_bytes_reg <= (req_addr_bytes_i > 3'd4) ? 3'd4 : req_addr_bytes_i;
          dummy_reg      <= req_dummy_i;
          len_reg        <= req_len_i;
          qpi_reg        <= req_qpi_i;
          csn_reg        <= req_csn_i;
        end
      end else if (abort_i && abortable) begin
        abort_reg <= 1'b1;
      end
    end
  end

  assign cmd_o       = cmd_word;
  assign cmd_valid_o = cmd_valid;
  assign busy_o      = (state_reg != IDLE);
  assign req_ready_o = (state_reg == IDLE);
  assign done_o      = done_reg;

endmodule

// File: tb/tb_udma_qspi_cmd_seq.sv
module tb_udma_qspi_cmd_seq;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [1:0]  req_op_i = '0;
  logic [7:0]  req_instr_i = '0;
  logic [31:0] req_addr_i = '0;
  logic [2:0]  req_addr_bytes_i = '0;
  logic [4:0]  req_dummy_i = '0;
  logic [15:0] req_len_i = '0;
  logic        req_qpi_i = 1'b0;
  logic [1:0]  req_csn_i = '0;
  logic        abort_i = 1'b0;
  logic [31:0] cmd_o;
  logic        cmd_valid_o;
  logic        cmd_ready_i = 1'b0;
  logic        eot_i = 1'b0;
  logic        busy_o;
  logic        done_o;

  always #5 clk = ~clk;

  udma_qspi_cmd_seq dut (
    .sys_clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_instr_i(req_instr_i), .req_addr_i(req_addr_i),
    .req_addr_bytes_i(req_addr_bytes_i), .req_dummy_i(req_dummy_i),
    .req_len_i(req_len_i), .req_qpi_i(req_qpi_i), .req_csn_i(req_csn_i),
    .abort_i(abort_i), .cmd_o(cmd_o), .cmd_valid_o(cmd_valid_o),
    .cmd_ready_i(cmd_ready_i), .eot_i(eot_i), .busy_o(busy_o), .done_o(done_o)
  );

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  instr;
    logic [31:0] addr;
    logic [2:0]  ab;
    logic [4:0]  dummy;
    logic [15:0] len;
    logic        qpi;
    logic [1:0]  csn;
  } req_t;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  int          hs_count = 0;
  int          done_seen = 0;
  logic        wait_eot_flag = 1'b0;
  int          ready_mode = 0;   // 0: always ready, 1: random, 2: manual
  logic        ready_manual = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] cmdw(input int bits, input logic [31:0] val, input logic q);
    return (32'h2 << 28) | (32'(q) << 27) | (32'(bits - 1) << 16) | (val & 32'hFFFF);
  endfunction

  function automatic int clamp_ab(input req_t r);
    return (r.ab > 3'd4) ? 4 : int'(r.ab);
  endfunction

  function automatic int count_words(input req_t r);
    int nab = clamp_ab(r);
    int n = 3;
    if (nab == 1 || nab == 2) n += 1;
    if (nab >= 3) n += 2;
    if (r.dummy != 0) n += 1;
    if (r.len != 0 && r.op < 2) n += 1;
    return n;
  endfunction

  task automatic push_expected(input req_t r, input int abort_k);
    logic [31:0] w[$];
    int nab;
    int lo_bits;
    nab = clamp_ab(r);
    w.push_back(32'h1000_0000 | 32'(r.csn));
    w.push_back(cmdw(8, 32'(r.instr), r.qpi));
    if (nab == 1 || nab == 2)
      w.push_back(cmdw(8 * nab, r.addr & ((32'd1 << (8 * nab)) - 1), r.qpi));
    if (nab >= 3) begin
      lo_bits = 8 * (nab - 2);
      w.push_back(cmdw(16, (r.addr >> lo_bits) & 32'hFFFF, r.qpi));
      w.push_back(cmdw(lo_bits, r.addr & ((32'd1 << lo_bits) - 1), r.qpi));
    end
    if (r.dummy != 0)
      w.push_back((32'h4 << 28) | (32'(r.dummy - 1) << 16));
    if (r.len != 0 && r.op < 2)
      w.push_back(((r.op == 0 ? 32'h7 : 32'h6) << 28) | (32'(r.qpi) << 27) | 32'(r.len - 1));
    if (abort_k >= 0) begin
      for (int i = 0; i <= abort_k; i++) exp_q.push_back(w[i]);
    end else begin
      foreach (w[i]) exp_q.push_back(w[i]);
    end
    exp_q.push_back(32'h9000_0001);
  endtask

  // ---------------- cmd_ready driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #2;
      cmd_ready_i = (ready_mode == 0) ? 1'b1 :
                    (ready_mode == 1) ? 1'($urandom_range(0, 1)) : ready_manual;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic        p_valid = 0, p_ready = 0, p_hs_noneot = 0, p_accept = 0, p_eot = 0;
  logic [31:0] p_word = '0;
  logic [31:0] popped;
  logic        cur_hs;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_i) begin
        p_valid = 0; p_ready = 0; p_hs_noneot = 0; p_accept = 0; p_eot = 0;
      end else begin
        cur_hs = cmd_valid_o && cmd_ready_i;
        if (p_valid && !p_ready) begin
          check("stall_valid", 32'(cmd_valid_o), 32'd1);
          check("stall_stable", cmd_o, p_word);
        end
        if (p_hs_noneot) check("word_spacing", 32'(cmd_valid_o), 32'd1);
        if (p_accept) check("accept_latency", 32'(cmd_valid_o), 32'd1);
        if (done_o || p_eot) check("done_pulse", 32'(done_o), 32'(p_eot));
        if (done_o) done_seen++;
        popped = 32'h9000_0001;
        if (cur_hs) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_word: got %08h expected no word", cmd_o);
          end else begin
            popped = exp_q.pop_front();
            check("word", cmd_o, popped);
          end
          hs_count++;
          $display("[TB] word %08h accepted", cmd_o);
        end
        p_valid     = cmd_valid_o;
        p_ready     = cmd_ready_i;
        p_word      = cmd_o;
        p_hs_noneot = cur_hs && (popped[31:28] != 4'h9);
        p_accept    = req_valid_i && req_ready_o;
        p_eot       = eot_i && wait_eot_flag;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input req_t r);
    req_op_i = r.op; req_instr_i = r.instr; req_addr_i = r.addr;
    req_addr_bytes_i = r.ab; req_dummy_i = r.dummy; req_len_i = r.len;
    req_qpi_i = r.qpi; req_csn_i = r.csn;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    check("busy_after_accept", 32'(busy_o), 32'd1);
  endtask

  task automatic step_to(input int target);
    int n = 0;
    while (hs_count < target && n < 1000) begin
      ready_manual = 1'b1;
      tick();
      n++;
    end
    ready_manual = 1'b0;
    check("step_to_count", hs_count, target);
  endtask

  task automatic finish_txn(input string tag);
    int n = 0;
    int d0;
    while ((exp_q.size() != 0 || cmd_valid_o) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got %0d words pending expected 0", tag, exp_q.size());
      exp_q.delete();
    end
    d0 = done_seen;
    wait_eot_flag = 1'b1;
    eot_i = 1'b1;
    tick();
    eot_i = 1'b0;
    wait_eot_flag = 1'b0;
    tick();
    tick();
    check("done_count", done_seen - d0, 32'd1);
    check("idle_ready", 32'(req_ready_o), 32'd1);
    check("idle_busy", 32'(busy_o), 32'd0);
    $display("[TB] transaction %s complete", tag);
  endtask

  task automatic run_txn(input req_t r, input int abort_k, input bit same_cycle,
                         input bit rand_ready, input bit pre_pushed, input string tag);
    int base = hs_count;
    if (!pre_pushed) push_expected(r, abort_k);
    if (abort_k < 0) begin
      ready_mode = rand_ready ? 1 : 0;
      issue(r);
    end else begin
      ready_mode = 2;
      ready_manual = 1'b0;
      issue(r);
      step_to(base + abort_k);
      abort_i = 1'b1;
      ready_manual = same_cycle;
      tick();
      abort_i = 1'b0;
      ready_manual = 1'b0;
      ready_mode = rand_ready ? 1 : 0;
    end
    finish_txn(tag);
  endtask

  // ---------------- main sequence ----------------
  req_t rd, cm, db, rr;
  int   d0, base, k;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_valid", 32'(cmd_valid_o), 32'd0);
    check("rst_cmd_o", cmd_o, 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_req_ready", 32'(req_ready_o), 32'd1);
    rst_i = 1'b0;
    tick();

    // Quad read example with fixed expected words
    rd = '{op: 2'd0, instr: 8'hEB, addr: 32'h0012_3456, ab: 3'd3, dummy: 5'd6,
           len: 16'd256, qpi: 1'b1, csn: 2'd1};
    exp_q.push_back(32'h1000_0001); exp_q.push_back(32'h2807_00EB);
    exp_q.push_back(32'h280F_1234); exp_q.push_back(32'h2807_0056);
    exp_q.push_back(32'h4005_0000); exp_q.push_back(32'h7800_00FF);
    exp_q.push_back(32'h9000_0001);
    run_txn(rd, -1, 0, 0, 1, "read");

    // Command-only: data length is ignored for op 2
    cm = '{op: 2'd2, instr: 8'h06, addr: 32'hFFFF_FFFF, ab: 3'd0, dummy: 5'd0,
           len: 16'd16, qpi: 1'b0, csn: 2'd0};
    exp_q.push_back(32'h1000_0000); exp_q.push_back(32'h2007_0006);
    exp_q.push_back(32'h9000_0001);
    run_txn(cm, -1, 0, 0, 1, "cmd_only");

    // Same read under random backpressure
    exp_q.push_back(32'h1000_0001); exp_q.push_back(32'h2807_00EB);
    exp_q.push_back(32'h280F_1234); exp_q.push_back(32'h2807_0056);
    exp_q.push_back(32'h4005_0000); exp_q.push_back(32'h7800_00FF);
    exp_q.push_back(32'h9000_0001);
    run_txn(rd, -1, 0, 1, 1, "backpressure");

    // Abort while ADDR_HI is stalled: ADDR_HI, then straight to EOT
    exp_q.push_back(32'h1000_0001); exp_q.push_back(32'h2807_00EB);
    exp_q.push_back(32'h280F_1234); exp_q.push_back(32'h9000_0001);
    run_txn(rd, 2, 0, 0, 1, "abort_addr_hi");

    // eot_i while idle must not produce done
    d0 = done_seen;
    eot_i = 1'b1; tick(); eot_i = 1'b0; tick(); tick();
    check("eot_idle_no_done", done_seen - d0, 32'd0);

    // 4-byte address, eot_i pulsed while DATA is stalled
    db = '{op: 2'd1, instr: 8'h0B, addr: 32'hDEAD_BEEF, ab: 3'd4, dummy: 5'd8,
           len: 16'd4, qpi: 1'b0, csn: 2'd2};
    exp_q.push_back(32'h1000_0002); exp_q.push_back(32'h2007_000B);
    exp_q.push_back(32'h200F_DEAD); exp_q.push_back(32'h200F_BEEF);
    exp_q.push_back(32'h4007_0000); exp_q.push_back(32'h6000_0003);
    exp_q.push_back(32'h9000_0001);
    base = hs_count;
    ready_mode = 2; ready_manual = 1'b0;
    issue(db);
    step_to(base + 5);
    check("data_valid_before_eot", 32'(cmd_valid_o), 32'd1);
    eot_i = 1'b1; tick(); eot_i = 1'b0;
    ready_mode = 0;
    finish_txn("eot_in_data");

    // Reset while DATA is presented
    push_expected(rd, -1);
    base = hs_count;
    ready_mode = 2; ready_manual = 1'b0;
    issue(rd);
    step_to(base + 5);
    check("pre_reset_valid", 32'(cmd_valid_o), 32'd1);
    rst_i = 1'b1;
    tick();
    check("mid_rst_cmd_valid", 32'(cmd_valid_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready_o), 32'd1);
    exp_q.delete();
    rst_i = 1'b0;
    tick();
    run_txn(db, -1, 0, 0, 0, "after_reset");

    // Randomised transactions, some aborted at a random word
    for (int t = 0; t < 40; t++) begin
      rr.op    = 2'($urandom_range(0, 3));
      rr.instr = 8'($urandom);
      rr.addr  = $urandom;
      rr.ab    = 3'($urandom_range(0, 7));
      rr.dummy = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      case ($urandom_range(0, 3))
        0: rr.len = 16'd0;
        1: rr.len = 16'd1;
        2: rr.len = 16'hFFFF;
        default: rr.len = 16'($urandom);
      endcase
      rr.qpi = 1'($urandom_range(0, 1));
      rr.csn = 2'($urandom_range(0, 3));
      k = -1;
      if ($urandom_range(0, 2) == 0) k = $urandom_range(0, count_words(rr) - 2);
      run_txn(rr, k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
